mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 39 +++
 rtl/mem_arbiter_rr_picker.sv | 21 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, access encodings
// and the latched memory command.
package PkgMemArbiter;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Access type and size encodings match the main memory interface.
  typedef enum logic {
    AccRead  = 1'b0,
    AccWrite = 1'b1
  } access_type_e;

  typedef enum logic [1:0] {
    Size32   = 2'd0,
    Size16   = 2'd1,
    Size8    = 2'd2,
    SizeRsvd = 2'd3
  } access_size_e;

  typedef enum logic {
    PortCpu = 1'b0,
    PortAux = 1'b1
  } port_e;

  typedef struct packed {
    logic [31:0]  addr;
    logic [31:0]  data;
    access_type_e access_type;
    access_size_e access_size;
  } cmd_t;

  localparam cmd_t CmdReset = '0;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Two-way round-robin winner selection. grant_o: 0 = CPU, 1 = aux.
module mem_arbiter_rr_picker (
  input  logic cpu_req_i,
  input  logic aux_req_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic grant_o
);

  // On a tie the port that was not granted last wins.
  always_comb begin
    valid_o = cpu_req_i | aux_req_i;
    grant_o = 1'b0;
    if (cpu_req_i && aux_req_i) begin
      grant_o = ~last_grant_i;
    end else if (aux_req_i) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and an auxiliary port onto a single memory port.
// One access at a time: IDLE -> ISSUE (one-cycle mem request) -> WAIT -> DONE (ack).
module mem_arbiter
  import PkgMemArbiter::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_access_type,
  input  logic [1:0]  cpu_access_size,
  output logic        cpu_wait_for_mem,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,

  input  logic        aux_req,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  input  logic        aux_access_type,
  input  logic [1:0]  aux_access_size,
  output logic        aux_wait_for_mem,
  output logic [31:0] aux_rdata,
  output logic        aux_err,

  output logic        mem_req_mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_out,
  output logic        mem_access_type,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_data_in,
  input  logic        mem_wait_for_mem
);

  localparam logic [31:0] TimeoutCnt = 32'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  port_e       owner_q, owner_d;
  port_e       last_grant_q, last_grant_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;

  logic        pick_valid;
  logic        pick_grant;
  logic        cpu_ack;
  logic        aux_ack;

  mem_arbiter_rr_picker u_picker (
    .cpu_req_i    (cpu_req),
    .aux_req_i    (aux_req),
    .last_grant_i (last_grant_q == PortAux),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    timeout_d    = timeout_q;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          if (pick_grant) begin
            owner_d = PortAux;
            cmd_d   = '{addr:        aux_addr,
                        data:        aux_wdata,
                        access_type: access_type_e'(aux_access_type),
                        access_size: access_size_e'(aux_access_size)};
          end else begin
            owner_d = PortCpu;
            cmd_d   = '{addr:        cpu_addr,
                        data:        cpu_wdata,
                        access_type: access_type_e'(cpu_access_type),
                        access_size: access_size_e'(cpu_access_size)};
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Memory's wait flag is not meaningful in the request cycle.
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 32'd1;
        if (!mem_wait_for_mem) begin
          rdata_d = mem_data_in;
          state_d = StDone;
        end else if (cnt_q + 32'd1 >= TimeoutCnt) begin
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = StDone;
        end
      end
      StDone: begin
        last_grant_d = owner_q;
        cnt_d        = '0;
        timeout_d    = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= CmdReset;
      owner_q      <= PortCpu;
      last_grant_q <= PortAux;
      cnt_q        <= '0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  // Requester-side outputs: only the owner sees data/err, and only in its ack cycle.
  always_comb begin
    cpu_ack          = (state_q == StDone) && (owner_q == PortCpu);
    aux_ack          = (state_q == StDone) && (owner_q == PortAux);
    cpu_wait_for_mem = cpu_req & ~cpu_ack;
    aux_wait_for_mem = aux_req & ~aux_ack;
    cpu_rdata        = cpu_ack ? rdata_q : 32'h0;
    aux_rdata        = aux_ack ? rdata_q : 32'h0;
    cpu_err          = cpu_ack & timeout_q;
    aux_err          = aux_ack & timeout_q;
  end

  // Memory-side outputs: the latched command is driven continuously.
  always_comb begin
    mem_req_mem_access = (state_q == StIssue);
    mem_addr           = cmd_q.addr;
    mem_data_out       = cmd_q.data;
    mem_access_type    = cmd_q.access_type;
    mem_access_size    = cmd_q.access_size;
  end

endmodule
